dr_xor3_sequencer: RTL and testbench
====================================

Name: dr_xor3_sequencer

Overview:
Precharge/evaluate controller for a W-bit array of dual-rail 3-input XOR cells, used for AddRoundKey-style mixing in the side-channel-hardened AES core. Accepts single-rail operands over a valid/ready handshake. Drives the array with an all-zero spacer (precharge) and then dual-rail encoded data (evaluate). Detects completion and rail faults, and returns a single-rail result plus a fault flag over a second valid/ready handshake.

Parameters:
W, 128, operand/result width in bits (1..256).
PRE_CYC, 2, minimum spacer cycles before each evaluate (>=1).
EVAL_CYC, 1, minimum evaluate cycles before completion is accepted (>=1).
TIMEOUT, 64, maximum cycles waiting in PRE or EVAL before a fault is declared (> PRE_CYC, EVAL_CYC).

Ports:
clk  in  1  clock, all state on rising edge.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  operand handshake valid.
in_ready  out  1  operand handshake ready.
in_a, in_b, in_c  in  W each  single-rail operands.
dr_a_t, dr_a_f, dr_b_t, dr_b_f, dr_c_t, dr_c_f  out  W each  dual-rail drive to the XOR3 array.
dr_o_t, dr_o_f  in  W each  dual-rail result from the XOR3 array.
out_valid  out  1  result handshake valid.
out_ready  in  1  result handshake ready.
out_data  out  W  single-rail result.
out_fault  out  1  result is invalid; qualified by out_valid.
busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, immediate): state=IDLE, all dr_* outputs 0 (spacer), out_valid=0, out_data=0, out_fault=0, counters 0, operand regs 0. Reset asserted mid-operation aborts the operation with no output.
- All outputs are registered. dr_* change only on clk edges.
- States:
  - IDLE: spacer driven, in_ready=1. On in_valid: latch operands, clear counter, go to PRE. in_ready=0 in every other state.
  - PRE: spacer driven, counter increments each cycle. Go to EVAL when counter>=PRE_CYC-1 and (dr_o_t|dr_o_f)==0 sampled that cycle. Go to FAULT when counter reaches TIMEOUT-1 without this.
  - EVAL: drive x_t=x, x_f=~x for x in {a,b,c}, counter restarts at 0. Per bit: complete = t^f, conflict = t&f.
    - Any conflict bit in any cycle: go to FAULT, which takes priority.
    - Else, all bits complete and counter>=EVAL_CYC-1: register out_data=dr_o_t, go to DONE.
    - Else, counter reaches TIMEOUT-1: go to FAULT.
  - DONE: spacer driven again in the same transition edge, out_valid=1, out_fault=0. Hold out_data and out_valid until out_valid&out_ready, then go to IDLE with out_valid=0 on the next edge.
  - FAULT: spacer driven, out_valid=1, out_fault=1, out_data=0. Leave on the handshake exactly as in DONE.
- Back-to-back operation: in_valid seen in IDLE the cycle after the output handshake. IDLE→IDLE accepts are not merged with DONE; there is one dead cycle per operation by design.
- Minimum latency: in-accept edge to out_valid = 1 (IDLE→PRE) + PRE_CYC + EVAL_CYC cycles. With defaults this is 4 cycles when the array settles within one cycle.
- Operands are never driven in the evaluate encoding while in any state other than EVAL. The spacer→data and data→spacer transitions are the only rail transitions, so each rail switches once per evaluate.
- Counter width is clog2(TIMEOUT)+1, saturating and never wrapping.
- Simultaneous in_valid during DONE/FAULT is ignored (in_ready=0). out_ready while out_valid=0 has no effect.

Decomposition:
- Shared package/include dr_pkg: state encoding localparams (IDLE, PRE, EVAL, DONE, FAULT), spacer constant, and the dual-rail encode function (t=x, f=~x).
- One sub-module: dr_completion_detect (W parameter). Inputs: t and f vectors. Outputs: all_spacer, all_complete, any_conflict. Purely combinational, reduction trees only.
- The FSM, counter and handshake stay in dr_xor3_sequencer.

Test Plan:
- Nominal: a=0x0F..0F, b=0xFF..00, c=0x12..34 with an ideal 1-cycle array model → out_data=a^b^c, out_fault=0, out_valid 4 cycles after accept. Check dr_* are 0 in all cycles outside EVAL.
- Backpressure: hold out_ready=0 for 10 cycles → out_valid and out_data stable, in_ready=0 throughout. Release → IDLE next edge, then accept the next operand.
- Conflict fault: model forces bit 5 t=f=1 in EVAL → FAULT entered next edge, out_fault=1, out_data=0, spacer driven.
- Stuck spacer: model holds dr_o_t[0]=1 during PRE → FAULT after exactly TIMEOUT cycles in PRE.
- Slow array: completion arrives 7 cycles into EVAL → DONE with the correct result and no fault. With the array never completing → FAULT at TIMEOUT.
- Async reset asserted mid-EVAL → all outputs 0 immediately, without waiting for a clock. After release, state is IDLE with in_ready=1 and no spurious out_valid.

Source files
------------

// File: rtl/dr_pkg.sv
// Shared definitions for the dual-rail XOR3 sequencer: FSM states, the spacer
// value and the single-rail to dual-rail encoding.
package dr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_EVAL,
    ST_DONE,
    ST_FAULT
  } dr_state_e;

  // Both rails low is the spacer (precharge) code for one dual-rail bit.
  localparam logic SPACER_BIT = 1'b0;

  // Returns {true_rail, false_rail} for one single-rail bit.
  function automatic logic [1:0] dr_encode(input logic x);
    return {x, ~x};
  endfunction

endpackage

// File: rtl/dr_completion_detect.sv
// Reduction-tree status of a dual-rail vector: all spacer, every bit carrying
// a valid code, or any bit with both rails high.
module dr_completion_detect #(
  parameter int W = 128
) (
  input  logic [W-1:0] t_i,
  input  logic [W-1:0] f_i,
  output logic         all_spacer_o,
  output logic         all_complete_o,
  output logic         any_conflict_o
);

  assign all_spacer_o   = ~|(t_i | f_i);
  assign all_complete_o = &(t_i ^ f_i);
  assign any_conflict_o = |(t_i & f_i);

endmodule

// File: rtl/dr_xor3_sequencer.sv
// Precharge/evaluate controller for a dual-rail XOR3 array: spacer, then data,
// completion and rail-fault detection, and a single-rail result handshake.
module dr_xor3_sequencer
  import dr_pkg::*;
#(
  parameter int W        = 128,
  parameter int PRE_CYC  = 2,
  parameter int EVAL_CYC = 1,
  parameter int TIMEOUT  = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic [W-1:0] in_c,
  output logic [W-1:0] dr_a_t,
  output logic [W-1:0] dr_a_f,
  output logic [W-1:0] dr_b_t,
  output logic [W-1:0] dr_b_f,
  output logic [W-1:0] dr_c_t,
  output logic [W-1:0] dr_c_f,
  input  logic [W-1:0] dr_o_t,
  input  logic [W-1:0] dr_o_f,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_fault,
  output logic         busy
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] TO_LIM   = CW'(TIMEOUT - 1);
  localparam logic [CW:0]   ONE      = (CW+1)'(1);
  localparam logic [CW:0]   PRE_NEED = (CW+1)'(PRE_CYC);
  localparam logic [CW:0]   EVAL_NEED = (CW+1)'(EVAL_CYC);

  dr_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [W-1:0]  a_q, a_d, b_q, b_d, c_q, c_d;
  logic [W-1:0]  a_t_q, a_t_d, a_f_q, a_f_d;
  logic [W-1:0]  b_t_q, b_t_d, b_f_q, b_f_d;
  logic [W-1:0]  c_t_q, c_t_d, c_f_q, c_f_d;
  logic          out_valid_q, out_valid_d, out_fault_q, out_fault_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic          in_ready_q, in_ready_d, busy_q, busy_d;
  logic          all_spacer, all_complete, any_conflict;
  logic          pre_min_met, eval_min_met, timed_out;

  dr_completion_detect #(.W(W)) u_detect (
    .t_i            (dr_o_t),
    .f_i            (dr_o_f),
    .all_spacer_o   (all_spacer),
    .all_complete_o (all_complete),
    .any_conflict_o (any_conflict)
  );

  // Counter saturates instead of wrapping so a long stall can never look fresh.
  assign cnt_inc      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  assign pre_min_met  = ({1'b0, cnt_q} + ONE) >= PRE_NEED;
  assign eval_min_met = ({1'b0, cnt_q} + ONE) >= EVAL_NEED;
  assign timed_out    = cnt_q >= TO_LIM;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_inc;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    out_valid_d = out_valid_q;
    out_fault_d = out_fault_q;
    out_data_d  = out_data_q;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          c_d     = in_c;
          state_d = ST_PRE;
        end
      end
      ST_PRE: begin
        if (pre_min_met && all_spacer) begin
          state_d = ST_EVAL;
          cnt_d   = '0;
        end else if (timed_out) begin
          state_d     = ST_FAULT;
          out_valid_d = 1'b1;
          out_fault_d = 1'b1;
          out_data_d  = '0;
        end
      end
      ST_EVAL: begin
        // A conflict anywhere outranks completion: the result cannot be trusted.
        if (any_conflict || (!(all_complete && eval_min_met) && timed_out)) begin
          state_d     = ST_FAULT;
          out_valid_d = 1'b1;
          out_fault_d = 1'b1;
          out_data_d  = '0;
        end else if (all_complete && eval_min_met) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
          out_fault_d = 1'b0;
          out_data_d  = dr_o_t;
        end
      end
      ST_DONE, ST_FAULT: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          out_fault_d = 1'b0;
          out_data_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Rails carry data only while the next state is EVAL, so each rail toggles once.
    a_t_d = {W{SPACER_BIT}};
    a_f_d = {W{SPACER_BIT}};
    b_t_d = {W{SPACER_BIT}};
    b_f_d = {W{SPACER_BIT}};
    c_t_d = {W{SPACER_BIT}};
    c_f_d = {W{SPACER_BIT}};
    if (state_d == ST_EVAL) begin
      for (int i = 0; i < W; i++) begin
        {a_t_d[i], a_f_d[i]} = dr_encode(a_q[i]);
        {b_t_d[i], b_f_d[i]} = dr_encode(b_q[i]);
        {c_t_d[i], c_f_d[i]} = dr_encode(c_q[i]);
      end
    end

    in_ready_d = (state_d == ST_IDLE);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      a_t_q       <= '0;
      a_f_q       <= '0;
      b_t_q       <= '0;
      b_f_q       <= '0;
      c_t_q       <= '0;
      c_f_q       <= '0;
      out_valid_q <= 1'b0;
      out_fault_q <= 1'b0;
      out_data_q  <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      a_t_q       <= a_t_d;
      a_f_q       <= a_f_d;
      b_t_q       <= b_t_d;
      b_f_q       <= b_f_d;
      c_t_q       <= c_t_d;
      c_f_q       <= c_f_d;
      out_valid_q <= out_valid_d;
      out_fault_q <= out_fault_d;
      out_data_q  <= out_data_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign dr_a_t    = a_t_q;
  assign dr_a_f    = a_f_q;
  assign dr_b_t    = b_t_q;
  assign dr_b_f    = b_f_q;
  assign dr_c_t    = c_t_q;
  assign dr_c_f    = c_f_q;
  assign out_valid = out_valid_q;
  assign out_fault = out_fault_q;
  assign out_data  = out_data_q;
  assign in_ready  = in_ready_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_dr_xor3_sequencer.sv
// Randomized and directed bench for dr_xor3_sequencer with a delayed dual-rail
// XOR3 array model and a result scoreboard.
module tb_dr_xor3_sequencer;

  localparam int W        = 128;
  localparam int PRE_CYC  = 2;
  localparam int EVAL_CYC = 1;
  localparam int TIMEOUT  = 64;
  localparam int MAXD     = 8;

  logic         clk, rst;
  logic         in_valid, in_ready;
  logic [W-1:0] in_a, in_b, in_c;
  logic [W-1:0] dr_a_t, dr_a_f, dr_b_t, dr_b_f, dr_c_t, dr_c_f;
  logic [W-1:0] dr_o_t, dr_o_f;
  logic         out_valid, out_ready, out_fault, busy;
  logic [W-1:0] out_data;

  dr_xor3_sequencer #(
    .W(W), .PRE_CYC(PRE_CYC), .EVAL_CYC(EVAL_CYC), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .dr_a_t(dr_a_t), .dr_a_f(dr_a_f), .dr_b_t(dr_b_t), .dr_b_f(dr_b_f),
    .dr_c_t(dr_c_t), .dr_c_f(dr_c_f),
    .dr_o_t(dr_o_t), .dr_o_f(dr_o_f),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_fault(out_fault), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [W-1:0] data;
    logic         fault;
  } exp_t;
  exp_t sbq[$];

  logic [W-1:0] curA = '0, curB = '0, curC = '0;

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Array model: 0 normal, 1 bit-5 conflict, 2 true rail of bit 0 stuck high, 3 never completes.
  int arrMode = 0;
  int arrDelay = 1;
  logic         histData[MAXD];
  logic [W-1:0] histXor[MAXD];
  logic [W-1:0] modelT, modelF;

  initial begin
    for (int i = 0; i < MAXD; i++) begin
      histData[i] = 1'b0;
      histXor[i]  = '0;
    end
    dr_o_t = '0;
    dr_o_f = '0;
  end

  always @(posedge clk) begin
    for (int i = MAXD - 1; i > 0; i--) begin
      histData[i] = histData[i-1];
      histXor[i]  = histXor[i-1];
    end
    histData[0] = (dr_a_t == ~dr_a_f) && (dr_b_t == ~dr_b_f) && (dr_c_t == ~dr_c_f);
    histXor[0]  = dr_a_t ^ dr_b_t ^ dr_c_t;
    modelT = '0;
    modelF = '0;
    if (arrMode != 3 && histData[arrDelay-1]) begin
      modelT = histXor[arrDelay-1];
      modelF = ~modelT;
    end
    if (arrMode == 1 && histData[arrDelay-1]) begin
      modelT[5] = 1'b1;
      modelF[5] = 1'b1;
    end
    if (arrMode == 2) modelT[0] = 1'b1;
    dr_o_t <= modelT;
    dr_o_f <= modelF;
  end

  // Per-cycle compare: legal rail codes, spacer outside evaluation, scoreboard on handshake.
  always @(negedge clk) begin
    if (!rst) begin
      logic railsOk;
      exp_t e;
      railsOk = ((dr_a_t | dr_a_f) == '0 || (dr_a_t == curA && dr_a_f == ~curA)) &&
                ((dr_b_t | dr_b_f) == '0 || (dr_b_t == curB && dr_b_f == ~curB)) &&
                ((dr_c_t | dr_c_f) == '0 || (dr_c_t == curC && dr_c_f == ~curC));
      checkOutput("rail encoding legal", W'(railsOk), W'(1));
      if (in_ready || out_valid)
        checkOutput("spacer outside eval", dr_a_t | dr_a_f | dr_b_t | dr_b_f | dr_c_t | dr_c_f, '0);
      checkOutput("in_ready with out_valid", W'(in_ready && out_valid), '0);
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          checkOutput("unexpected result", W'(1), W'(0));
        end else begin
          e = sbq.pop_front();
          checkOutput("result data", out_data, e.data);
          checkOutput("result fault", W'(out_fault), W'(e.fault));
        end
      end
    end
  end

  function automatic logic [W-1:0] randW();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                               input int mode, input int delay, input int expLat, input int hold,
                               input logic pinEn, input logic [W-1:0] pinVal);
    int waitc;
    int lat;
    exp_t e;
    waitc = 0;
    while (!in_ready && waitc < 200) begin
      @(posedge clk);
      #1;
      waitc++;
    end
    if (!in_ready) begin
      checkOutput("in_ready wait", W'(0), W'(1));
      return;
    end
    arrMode  = mode;
    arrDelay = delay;
    e.data   = (mode == 0) ? (a ^ b ^ c) : '0;
    e.fault  = (mode != 0);
    sbq.push_back(e);
    curA = a; curB = b; curC = c;
    in_a = a; in_b = b; in_c = c;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a = randW(); in_b = randW(); in_c = randW();
    lat = 0;
    while (!out_valid && lat < 400) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("out_valid arrives", W'(out_valid), W'(1));
    if (!out_valid) return;
    if (expLat >= 0) checkOutput("latency", W'(lat), W'(expLat));
    if (pinEn) checkOutput("pinned result", out_data, pinVal);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      checkOutput("held out_valid", W'(out_valid), W'(1));
      checkOutput("held out_data", out_data, e.data);
      checkOutput("held in_ready", W'(in_ready), W'(0));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput("out_valid drops", W'(out_valid), W'(0));
    checkOutput("idle after handshake", W'(in_ready), W'(1));
  endtask

  initial begin
    logic [W-1:0] a, b, c;
    rst = 1'b1;
    in_valid = 1'b0;
    in_a = '0; in_b = '0; in_c = '0;
    out_ready = 1'b0;
    idleCycles(3);
    checkOutput("reset dr rails", dr_a_t | dr_a_f | dr_b_t | dr_b_f | dr_c_t | dr_c_f, '0);
    checkOutput("reset out_valid", W'(out_valid), W'(0));
    checkOutput("reset out_data", out_data, '0);
    checkOutput("reset busy", W'(busy), W'(0));
    checkOutput("reset in_ready", W'(in_ready), W'(1));
    rst = 1'b0;
    idleCycles(2);

    $display("[TB] nominal operation");
    applyStimulus({16{8'h0F}}, {8{16'hFF00}}, {8{16'h1234}}, 0, 1, 4, 0, 1'b1, {8{16'hE23B}});

    $display("[TB] backpressure and back-to-back");
    applyStimulus(randW(), randW(), randW(), 0, 1, 4, 10, 1'b0, '0);
    applyStimulus(randW(), randW(), randW(), 0, 1, 4, 0, 1'b0, '0);

    $display("[TB] conflict fault");
    idleCycles(12);
    applyStimulus(randW(), randW(), randW(), 1, 1, PRE_CYC + 2, 2, 1'b1, '0);

    $display("[TB] stuck spacer");
    idleCycles(12);
    applyStimulus(randW(), randW(), randW(), 2, 1, TIMEOUT, 1, 1'b1, '0);

    $display("[TB] slow array");
    arrMode = 0;
    idleCycles(12);
    applyStimulus({16{8'h0F}}, {8{16'hFF00}}, {8{16'h1234}}, 0, 7, PRE_CYC + 8, 0, 1'b1, {8{16'hE23B}});

    $display("[TB] array never completes");
    idleCycles(12);
    applyStimulus(randW(), randW(), randW(), 3, 1, PRE_CYC + TIMEOUT, 0, 1'b1, '0);

    $display("[TB] randomized operations");
    arrMode = 0;
    idleCycles(12);
    for (int n = 0; n < 24; n++) begin
      applyStimulus(randW(), randW(), randW(), ($urandom_range(0, 4) == 0) ? 1 : 0,
                    $urandom_range(1, 4), -1, $urandom_range(0, 3), 1'b0, '0);
      idleCycles($urandom_range(0, 2));
    end

    $display("[TB] reset during evaluate");
    arrMode = 0;
    arrDelay = 7;
    idleCycles(12);
    a = randW(); b = randW(); c = randW();
    curA = a; curB = b; curC = c;
    in_a = a; in_b = b; in_c = c;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    idleCycles(3);
    checkOutput("evaluating before reset", dr_a_t, a);
    rst = 1'b1;
    #1;
    checkOutput("async reset dr rails", dr_a_t | dr_a_f | dr_b_t | dr_b_f | dr_c_t | dr_c_f, '0);
    checkOutput("async reset out_valid", W'(out_valid), W'(0));
    checkOutput("async reset out_fault", W'(out_fault), W'(0));
    checkOutput("async reset busy", W'(busy), W'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("ready after reset", W'(in_ready), W'(1));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checkOutput("no spurious out_valid", W'(out_valid), W'(0));
    end

    $display("[TB] operation after reset");
    applyStimulus(randW(), randW(), randW(), 0, 1, 4, 1, 1'b0, '0);

    checkOutput("scoreboard drained", W'(sbq.size()), W'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
